// File: rtl/sr_bank_writer_pkg.sv
// -----------------------------------------------------------------------------
// sr_bank_pkg
// Shared types and constants for the SR cell bank writer.
//   sr_wr_state_t : write-sequence FSM states (IDLE, PULSE, GAP, CHECK)
//   SYNC_STAGES   : depth of the per-bit Q readback synchronizer
//   sr_max        : integer maximum, used to size the shared timing counter
// -----------------------------------------------------------------------------
package sr_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      CHECK = 2'd3
   } sr_wr_state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int sr_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sr_bank_writer_sync.sv
// -----------------------------------------------------------------------------
// sr_sync2
// Single-bit multi-flop synchronizer (SYNC_STAGES deep) for a cell Q output
// that changes asynchronously to clk.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, all stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output, SYNC_STAGES cycles of latency
// -----------------------------------------------------------------------------
module sr_sync2
   import sr_bank_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/sr_bank_writer.sv
// -----------------------------------------------------------------------------
// sr_bank_writer
// Write-side driver for a bank of N external SR latches. Each accepted request
// becomes a PULSE_CYCLES-wide pulse on the target cell's S (val=1) or R (val=0)
// line, followed by GAP_CYCLES+2 all-low cycles, then a one-cycle CHECK where
// the synchronized Q of the cell is compared with the written value.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_valid : request present
//   req_ready : request can be accepted (IDLE only)
//   req_idx   : target cell index (values >= N are rejected with an error)
//   req_val   : value to write (1 -> S pulse, 0 -> R pulse)
//   s_out     : Set lines, at most one bit high
//   r_out     : Reset lines, at most one bit high, never together with s_out
//   q_in      : cell Q outputs, asynchronous to clk
//   done      : one-cycle completion pulse
//   err       : one-cycle failure pulse, coincident with done
//   err_idx   : index of the most recent failed request
// -----------------------------------------------------------------------------
module sr_bank_writer
   import sr_bank_pkg::*;
#(
   parameter int N            = 8,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1,
   parameter int IW           = $clog2(N)
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [IW-1:0] req_idx,
   input  logic          req_val,
   output logic [N-1:0]  s_out,
   output logic [N-1:0]  r_out,
   input  logic [N-1:0]  q_in,
   output logic          done,
   output logic          err,
   output logic [IW-1:0] err_idx
);

   // One down-counter times both the pulse and the gap; the gap includes the
   // synchronizer latency so the CHECK sample reflects the post-pulse Q.
   localparam int CNT_MAX = sr_max(PULSE_CYCLES, GAP_CYCLES + SYNC_STAGES);
   localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES + SYNC_STAGES - 1);

   sr_wr_state_t  state_reg, state_next;
   logic [CW-1:0] cnt_reg,   cnt_next;
   logic [IW-1:0] idx_reg,   idx_next;
   logic          val_reg,   val_next;
   logic          oor_reg,   oor_next;

   logic [N-1:0]  s_reg,     s_next;
   logic [N-1:0]  r_reg,     r_next;
   logic          done_reg,  done_next;
   logic          err_reg,   err_next;
   logic [IW-1:0] err_idx_reg, err_idx_next;
   logic          ready_reg, ready_next;

   logic [N-1:0]  q_sync;
   logic [N-1:0]  idx_hot;
   logic          q_sel;
   logic          req_oor;

   // ------------------------------------------------------------------
   // Per-bit synchronizers for the asynchronous Q readback
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_sync
         sr_sync2 u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (q_in[gi]),
            .q     (q_sync[gi])
         );
      end
   endgenerate

   // One-hot decode of the index the outputs will carry next cycle. An
   // out-of-range index decodes to all zeros, so it can never pulse a line.
   generate
      for (gi = 0; gi < N; gi++) begin : g_dec
         assign idx_hot[gi] = (idx_next == IW'(gi));
      end
   endgenerate

   assign q_sel   = |(q_sync & idx_hot);
   assign req_oor = ({1'b0, req_idx} >= (IW+1)'(N));

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      val_next   = val_reg;
      oor_next   = oor_reg;

      case (state_reg)
         IDLE: begin
            if (req_valid && ready_reg) begin
               idx_next = req_idx;
               val_next = req_val;
               if (req_oor) begin
                  oor_next   = 1'b1;
                  state_next = CHECK;
               end else begin
                  oor_next   = 1'b0;
                  cnt_next   = PULSE_LOAD;
                  state_next = PULSE;
               end
            end
         end
         PULSE: begin
            if (cnt_reg == '0) begin
               cnt_next   = GAP_LOAD;
               state_next = GAP;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         GAP: begin
            if (cnt_reg == '0) begin
               state_next = CHECK;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         CHECK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic, computed from the next state so every output is a flop
   // aligned with the state it belongs to (glitch-free S/R lines).
   // ------------------------------------------------------------------
   always_comb begin
      s_next       = '0;
      r_next       = '0;
      done_next    = 1'b0;
      err_next     = 1'b0;
      err_idx_next = err_idx_reg;
      ready_next   = (state_next == IDLE);

      if (state_next == PULSE) begin
         if (val_next) begin
            s_next = idx_hot;
         end else begin
            r_next = idx_hot;
         end
      end

      if (state_next == CHECK) begin
         done_next = 1'b1;
         err_next  = oor_next || (q_sel != val_next);
         if (err_next) begin
            err_idx_next = idx_next;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         val_reg     <= 1'b0;
         oor_reg     <= 1'b0;
         s_reg       <= '0;
         r_reg       <= '0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         err_idx_reg <= '0;
         ready_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         val_reg     <= val_next;
         oor_reg     <= oor_next;
         s_reg       <= s_next;
         r_reg       <= r_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         err_idx_reg <= err_idx_next;
         ready_reg   <= ready_next;
      end
   end

   assign s_out     = s_reg;
   assign r_out     = r_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign err_idx   = err_idx_reg;
   assign req_ready = ready_reg;

endmodule

// File: tb/tb_sr_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_sr_bank_writer
// Bench for sr_bank_writer: an N=8 instance driving a behavioural SR cell bank
// (with optional stuck-at-0 cells) and an N=6 instance for out-of-range
// requests. Expected per-cycle S/R/done/err/ready come from the timing rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sr_bank_writer;

   localparam int P   = 2;
   localparam int G   = 1;
   localparam int TOT = P + G + 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   // N=8 instance
   logic       req_valid8 = 1'b0;
   logic       ready8;
   logic [2:0] req_idx8 = '0;
   logic       req_val8 = 1'b0;
   logic [7:0] s8, r8;
   logic       done8, err8;
   logic [2:0] err_idx8;

   // N=6 instance
   logic       req_valid6 = 1'b0;
   logic       ready6;
   logic [2:0] req_idx6 = '0;
   logic       req_val6 = 1'b0;
   logic [5:0] s6, r6;
   logic       done6, err6;
   logic [2:0] err_idx6;

   // Behavioural cell bank: a cell follows its S/R lines unless stuck at 0.
   logic [7:0] cell_q = '0;
   logic [7:0] stuck  = '0;

   int vectors = 0;
   int fails   = 0;
   logic [2:0] exp_err_idx = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (stuck[i])      cell_q[i] <= 1'b0;
         else if (s8[i])    cell_q[i] <= 1'b1;
         else if (r8[i])    cell_q[i] <= 1'b0;
      end
   end

   sr_bank_writer #(.N(8), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid8), .req_ready(ready8),
      .req_idx(req_idx8), .req_val(req_val8),
      .s_out(s8), .r_out(r8), .q_in(cell_q),
      .done(done8), .err(err8), .err_idx(err_idx8)
   );

   sr_bank_writer #(.N(6), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid6), .req_ready(ready6),
      .req_idx(req_idx6), .req_val(req_val6),
      .s_out(s6), .r_out(r6), .q_in(6'h00),
      .done(done6), .err(err6), .err_idx(err_idx6)
   );

   // One full write on the N=8 instance. Called at a negedge with ready high;
   // returns at the negedge of the cycle in which ready is high again.
   task automatic write8(input logic [2:0] idx, input logic val, input logic hold);
      logic [7:0] hot;
      logic [7:0] exp_s, exp_r;
      logic       e_fail, exp_done, exp_err, exp_ready;
      hot    = 8'h01 << idx;
      e_fail = val && stuck[idx];
      $display("write idx=%0d val=%0d", idx, val);
      req_idx8   = idx;
      req_val8   = val;
      req_valid8 = 1'b1;
      vectors++;
      if (ready8 !== 1'b1) begin
         fails++;
         $display("FAIL accept_ready idx=%0d got=%b want=1", idx, ready8);
      end
      for (int k = 1; k <= TOT; k++) begin
         @(negedge clk);
         if (!hold) req_valid8 = 1'b0;
         exp_s     = (k <= P &&  val) ? hot : 8'h00;
         exp_r     = (k <= P && !val) ? hot : 8'h00;
         exp_done  = (k == P + G + 3);
         exp_err   = exp_done && e_fail;
         exp_ready = (k == TOT);
         if (exp_err) exp_err_idx = idx;
         vectors++;
         if (s8 !== exp_s || r8 !== exp_r) begin
            fails++;
            $display("FAIL sr_lines k=%0d got s=%h r=%h want s=%h r=%h", k, s8, r8, exp_s, exp_r);
         end
         vectors++;
         if (done8 !== exp_done || err8 !== exp_err) begin
            fails++;
            $display("FAIL done_err k=%0d got %b/%b want %b/%b", k, done8, err8, exp_done, exp_err);
         end
         vectors++;
         if (ready8 !== exp_ready) begin
            fails++;
            $display("FAIL ready k=%0d got=%b want=%b", k, ready8, exp_ready);
         end
         vectors++;
         if (err_idx8 !== exp_err_idx) begin
            fails++;
            $display("FAIL err_idx k=%0d got=%0d want=%0d", k, err_idx8, exp_err_idx);
         end
         vectors++;
         if ((s8 & r8) !== 8'h00 || $countones(s8 | r8) > 1) begin
            fails++;
            $display("FAIL invariant k=%0d s=%h r=%h", k, s8, r8);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      vectors++;
      if (s8 !== 8'h00 || r8 !== 8'h00 || done8 !== 1'b0 || err8 !== 1'b0 || err_idx8 !== 3'd0) begin
         fails++;
         $display("FAIL reset8 s=%h r=%h done=%b err=%b err_idx=%0d", s8, r8, done8, err8, err_idx8);
      end
      vectors++;
      if (s6 !== 6'h00 || r6 !== 6'h00 || done6 !== 1'b0 || err6 !== 1'b0 || err_idx6 !== 3'd0) begin
         fails++;
         $display("FAIL reset6 s=%h r=%h done=%b err=%b err_idx=%0d", s6, r6, done6, err6, err_idx6);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (ready8 !== 1'b1 || ready6 !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready got %b/%b want 1/1", ready8, ready6);
      end
      exp_err_idx = 3'd0;
   endtask

   task automatic test_set_reset();
      write8(3'd3, 1'b1, 1'b0);
      vectors++;
      if (cell_q[3] !== 1'b1) begin
         fails++;
         $display("FAIL cell3_set got=%b want=1", cell_q[3]);
      end
      write8(3'd3, 1'b0, 1'b0);
      vectors++;
      if (cell_q[3] !== 1'b0) begin
         fails++;
         $display("FAIL cell3_clear got=%b want=0", cell_q[3]);
      end
   endtask

   task automatic test_stuck();
      stuck[5] = 1'b1;
      write8(3'd5, 1'b1, 1'b0);   // fails, err_idx -> 5
      write8(3'd3, 1'b1, 1'b0);   // succeeds, err_idx must hold 5
      write8(3'd5, 1'b0, 1'b0);   // writing 0 to a stuck-at-0 cell succeeds
   endtask

   task automatic test_out_of_range();
      req_idx6   = 3'd7;
      req_val6   = 1'($urandom_range(0, 1));
      req_valid6 = 1'b1;
      $display("write6 idx=7 val=%0d", req_val6);
      vectors++;
      if (ready6 !== 1'b1) begin
         fails++;
         $display("FAIL oor_accept_ready got=%b want=1", ready6);
      end
      @(negedge clk);
      req_valid6 = 1'b0;
      vectors++;
      if (done6 !== 1'b1 || err6 !== 1'b1 || err_idx6 !== 3'd7) begin
         fails++;
         $display("FAIL oor_cycle1 got done=%b err=%b err_idx=%0d want 1/1/7", done6, err6, err_idx6);
      end
      vectors++;
      if (s6 !== 6'h00 || r6 !== 6'h00 || ready6 !== 1'b0) begin
         fails++;
         $display("FAIL oor_lines1 s=%h r=%h ready=%b want 0/0/0", s6, r6, ready6);
      end
      @(negedge clk);
      vectors++;
      if (ready6 !== 1'b1 || done6 !== 1'b0 || err6 !== 1'b0 || s6 !== 6'h00 || r6 !== 6'h00) begin
         fails++;
         $display("FAIL oor_cycle2 ready=%b done=%b err=%b s=%h r=%h", ready6, done6, err6, s6, r6);
      end
      vectors++;
      if (err_idx6 !== 3'd7) begin
         fails++;
         $display("FAIL oor_err_idx_hold got=%0d want=7", err_idx6);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 200; n++) begin
         write8(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      end
      req_valid8 = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      req_idx8   = 3'd2;
      req_val8   = 1'b1;
      req_valid8 = 1'b1;
      $display("write idx=2 val=1 (reset during pulse)");
      @(posedge clk);
      #2;
      req_valid8 = 1'b0;
      vectors++;
      if (s8 !== 8'h04) begin
         fails++;
         $display("FAIL pre_reset_pulse got s=%h want 04", s8);
      end
      rst_n = 1'b0;
      #1;
      exp_err_idx = 3'd0;
      vectors++;
      if (s8 !== 8'h00 || r8 !== 8'h00 || done8 !== 1'b0 || err_idx8 !== 3'd0) begin
         fails++;
         $display("FAIL async_reset s=%h r=%h done=%b err_idx=%0d", s8, r8, done8, err_idx8);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < TOT; k++) begin
         @(negedge clk);
         vectors++;
         if (done8 !== 1'b0 || s8 !== 8'h00 || r8 !== 8'h00 || ready8 !== 1'b1) begin
            fails++;
            $display("FAIL post_reset k=%0d done=%b s=%h r=%h ready=%b", k, done8, s8, r8, ready8);
         end
      end
      write8(3'd2, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_set_reset();
      test_stuck();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/sr_bank_writer.md
# sr_bank_writer

Write-side driver for a bank of `N` external SR storage cells (SR latches).
- Accepts single-bit write requests over a valid/ready handshake.
- Converts each request into a clean, width-controlled Set or Reset pulse on that cell's S or R line.
- Never drives S and R of any cell high at the same time.
- After each pulse, samples the cell's Q output through a synchronizer and reports success or a mismatch error.

## Interface
Parameters:
- `N`, 8: number of SR cells driven; must be ≥ 2.
- `PULSE_CYCLES`, 2: cycles the S or R line is held high per write; must be ≥ 1.
- `GAP_CYCLES`, 1: all-low recovery cycles after the pulse, before readback; must be ≥ 0.
- `IW`, `$clog2(N)`: width of the index field (derived).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `req_valid` in 1: a write request is presented.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_idx` in IW: index of the target cell.
- `req_val` in 1: value to write; 1 pulses S, 0 pulses R.
- `s_out` out N: Set lines to the cell bank.
- `r_out` out N: Reset lines to the cell bank.
- `q_in` in N: cell Q outputs; asynchronous to `clk`.
- `done` out 1: one-cycle pulse when a request completes.
- `err` out 1: one-cycle pulse, coincident with `done`, when the request failed.
- `err_idx` out IW: index of the last failed request; holds until the next error.

## Operation
FSM states: IDLE, PULSE, GAP, CHECK.

- **IDLE**
  - `req_ready`=1; `s_out`=`r_out`=0.
  - On `req_valid && req_ready`, latch `req_idx` and `req_val`.
  - If `idx ≥ N`: go to CHECK with a forced error; no pulse is issued.
  - Otherwise: go to PULSE.
- **PULSE**
  - For exactly `PULSE_CYCLES` cycles, drive `s_out[idx]`=`val` and `r_out[idx]`=`~val`.
  - All other bits stay 0.
  - Go to GAP.
- **GAP**
  - `s_out`=`r_out`=0 for `GAP_CYCLES`+2 cycles. The extra 2 cycles cover the 2-flop synchronizer latency.
  - Go to CHECK.
- **CHECK** (1 cycle)
  - `done`=1.
  - `err`=1 if the synchronized `q_in[idx]` != `val`, or if the index was out of range.
  - On error, `err_idx` is loaded with `idx`.
  - Go to IDLE.

Invariants:
- `s_out & r_out` == 0 in every cycle.
- `s_out | r_out` is zero or one-hot.

Reset behaviour:
- `q_in` passes through a 2-flop synchronizer per bit. Its flops reset to 0.
- Reset, including mid-operation, immediately forces:
  - FSM to IDLE
  - `s_out`=`r_out`=0
  - `done`=`err`=0
  - `err_idx`=0
  - `req_ready`=1 one cycle after deassertion, when the first rising edge returns the FSM to IDLE.

Handshake:
- `req_valid` is ignored outside IDLE.
- Requests are never queued.

## Timing
Take the accept edge as edge 0. With P = `PULSE_CYCLES` and G = `GAP_CYCLES`:
- Pulse: high in cycles 1..P (registered outputs, glitch-free).
- Gap: cycles P+1..P+G+2.
- `done`/`err`: high in cycle P+G+3.
- `req_ready`: high again in cycle P+G+4.
- Throughput: one write per P+G+4 cycles, which is 7 at default parameters.
- Out-of-range request: `done`=`err`=1 in cycle 1; `req_ready` high in cycle 2.
- `req_valid` held high continuously: a back-to-back request is accepted on the first IDLE edge.

## Structure
- Package `sr_bank_pkg` holds:
  - the state enum `sr_wr_state_t` (IDLE, PULSE, GAP, CHECK);
  - shared localparams for the sync depth (`SYNC_STAGES` = 2).
- Sub-module `sr_sync2` is the per-bit 2-flop synchronizer, instantiated N times via generate.
- The pulse and gap timing share one down-counter, sized `$clog2(max(P, G+2)+1)`.

## Test plan
- Reset, then request idx=3, val=1, with a behavioural SR cell model:
  - `s_out`=8'h08 in cycles 1–2;
  - `done`=1, `err`=0 in cycle 6;
  - model Q[3]=1.
- Request idx=3, val=0:
  - `r_out`=8'h08 in cycles 1–2, with `s_out`=0 throughout;
  - `done`=1, `err`=0.
- Stuck-at-0 cell 5 in the model, then request idx=5, val=1:
  - `err`=1 and `done`=1 in cycle 6;
  - `err_idx`=5 and it holds afterwards.
- `N`=6, request idx=7:
  - no S/R activity;
  - `done`=`err`=1 in cycle 1;
  - `err_idx`=7.
- `req_valid` held high with random idx/val for 200 requests:
  - a checker asserts `s_out & r_out`==0 and that at most one bit is set, every cycle;
  - exactly one accept per 7 cycles.
- Assert `rst_n`=0 during cycle 1 of a PULSE:
  - `s_out`/`r_out` go to 0 within the same cycle;
  - no `done` is issued;
  - after release, `req_ready`=1 and a fresh write completes normally.
